// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : CSR address map, write-operation encoding and address helpers
//               shared by the CSR file and its testbench-facing top.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
    localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
    localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
    localparam logic [11:0] CSR_CYCLE        = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
    localparam logic [11:0] CSR_INSTRET      = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH     = 12'hC82;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // Addresses with [11:10] == 2'b11 are read-only by architecture
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

    // Map the user-level read-only counter shadows onto the machine counters
    function automatic logic [11:0] csr_shadow_alias(input logic [11:0] addr);
        logic [11:0] v;
        v = addr;
        if ((addr == CSR_CYCLE) || (addr == CSR_CYCLEH) ||
            (addr == CSR_INSTRET) || (addr == CSR_INSTRETH)) begin
            v = addr ^ 12'h700;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter
// Description : CNT_W-bit free-running counter with increment enable and
//               independent low/high half write ports. A write to either
//               half suppresses the increment for that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [XLEN-1:0]  wr_data,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Half writes take priority over counting; the high half keeps only its own width
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) begin
                r_count[XLEN-1:0] <= wr_data;
            end
            if (wr_hi) begin
                r_count[CNT_W-1:XLEN] <= wr_data[CNT_W-XLEN-1:0];
            end
        end else if (inc_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : Machine-mode CSR file: mscratch, custom scratch bank, mcycle
//               and minstret with read-only shadows. Combinational read with
//               same-cycle bypass of the value being written.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file
    import csr_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int N_SCRATCH = 4,
    parameter int CNT_W     = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_illegal,
    input  logic            we,
    input  logic [11:0]     wr_addr,
    input  logic [1:0]      wr_op,
    input  logic [XLEN-1:0] wr_data,
    output logic            wr_illegal,
    input  logic            retire
);

    // Bits of an XLEN word that survive in a counter high half
    localparam logic [XLEN-1:0] C_HI_MASK = {XLEN{1'b1}} >> (2*XLEN - CNT_W);

    logic [XLEN-1:0]  r_mscratch;
    logic [XLEN-1:0]  r_scratch [N_SCRATCH];
    logic [CNT_W-1:0] w_mcycle;
    logic [CNT_W-1:0] w_minstret;

    logic             w_op_active;
    logic             w_wr_impl;
    logic             w_wr_eff;
    logic             w_wr_scratch;
    logic             w_wr_hi;
    logic [XLEN-1:0]  w_wr_old;
    logic [XLEN-1:0]  w_wr_new;
    logic [XLEN-1:0]  w_wr_new_vis;
    logic             w_rd_impl;
    logic             w_rd_bypass;

    function automatic logic is_scratch(input logic [11:0] a);
        return (a[11:4] == CSR_SCRATCH_BASE[11:4]) && ({1'b0, a[3:0]} < 5'(N_SCRATCH));
    endfunction

    function automatic logic is_impl(input logic [11:0] a);
        logic [11:0] m;
        m = csr_shadow_alias(a);
        return (m == CSR_MSCRATCH) || (m == CSR_MCYCLE) || (m == CSR_MCYCLEH) ||
               (m == CSR_MINSTRET) || (m == CSR_MINSTRETH) || is_scratch(a);
    endfunction

    // Current register contents at an address (0 if unimplemented)
    function automatic logic [XLEN-1:0] csr_read(input logic [11:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        case (csr_shadow_alias(a))
            CSR_MSCRATCH:  v = r_mscratch;
            CSR_MCYCLE:    v = w_mcycle[XLEN-1:0];
            CSR_MCYCLEH:   v = XLEN'(w_mcycle[CNT_W-1:XLEN]);
            CSR_MINSTRET:  v = w_minstret[XLEN-1:0];
            CSR_MINSTRETH: v = XLEN'(w_minstret[CNT_W-1:XLEN]);
            default: begin
                if (is_scratch(a)) begin
                    for (int i = 0; i < N_SCRATCH; i++) begin
                        if (a[3:0] == 4'(i)) v = r_scratch[i];
                    end
                end
            end
        endcase
        return v;
    endfunction

    assign w_op_active  = we && (wr_op != CSR_NONE);
    assign w_wr_impl    = is_impl(wr_addr);
    assign w_wr_eff     = w_op_active && w_wr_impl && !csr_is_ro(wr_addr);
    assign wr_illegal   = w_op_active && (!w_wr_impl || csr_is_ro(wr_addr));
    assign w_wr_scratch = is_scratch(wr_addr);
    assign w_wr_hi      = (wr_addr == CSR_MCYCLEH) || (wr_addr == CSR_MINSTRETH);
    assign w_wr_old     = csr_read(wr_addr);

    // Read-modify-write value for the addressed register
    always_comb begin
        w_wr_new = w_wr_old;
        case (csr_op_e'(wr_op))
            CSR_RW:  w_wr_new = wr_data;
            CSR_RS:  w_wr_new = w_wr_old | wr_data;
            CSR_RC:  w_wr_new = w_wr_old & ~wr_data;
            default: w_wr_new = w_wr_old;
        endcase
    end

    // Bypassed value as it will read after commit (high halves truncated)
    assign w_wr_new_vis = w_wr_hi ? (w_wr_new & C_HI_MASK) : w_wr_new;

    assign w_rd_impl   = is_impl(rd_addr);
    assign w_rd_bypass = w_wr_eff && (csr_shadow_alias(rd_addr) == wr_addr);
    assign rd_illegal  = !w_rd_impl;
    assign rd_data     = !w_rd_impl  ? '0 :
                         w_rd_bypass ? w_wr_new_vis : csr_read(rd_addr);

    // mscratch update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mscratch <= '0;
        end else if (w_wr_eff && (wr_addr == CSR_MSCRATCH)) begin
            r_mscratch <= w_wr_new;
        end
    end

    // Scratch bank: entry chosen by wr_addr[3:0] once the range compare hits
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SCRATCH; i++) r_scratch[i] <= '0;
        end else if (w_wr_eff && w_wr_scratch) begin
            for (int i = 0; i < N_SCRATCH; i++) begin
                if (wr_addr[3:0] == 4'(i)) r_scratch[i] <= w_wr_new;
            end
        end
    end

    csr_counter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (1'b1),
        .wr_lo   (w_wr_eff && (wr_addr == CSR_MCYCLE)),
        .wr_hi   (w_wr_eff && (wr_addr == CSR_MCYCLEH)),
        .wr_data (w_wr_new),
        .count   (w_mcycle)
    );

    csr_counter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (retire),
        .wr_lo   (w_wr_eff && (wr_addr == CSR_MINSTRET)),
        .wr_hi   (w_wr_eff && (wr_addr == CSR_MINSTRETH)),
        .wr_data (w_wr_new),
        .count   (w_minstret)
    );

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_file
// Description : Self-checking bench for csr_file (default parameters):
//               directed vector table, hand-written counter/reset sequences
//               and randomized traffic against a behavioural CSR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_illegal;
    logic        we = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [1:0]  wr_op = 2'b00;
    logic [31:0] wr_data = '0;
    logic        wr_illegal;
    logic        retire = 1'b0;

    always #5 clk = ~clk;

    csr_file dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_illegal (rd_illegal),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_op      (wr_op),
        .wr_data    (wr_data),
        .wr_illegal (wr_illegal),
        .retire     (retire)
    );

    // Architectural state of the model: whole counters as plain 64-bit numbers
    typedef struct packed {
        logic [31:0]      ms;
        logic [3:0][31:0] sc;
        logic [63:0]      cyc;
        logic [63:0]      ins;
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  op;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        ret;
        logic [11:0] ra;
        logic [31:0] e_rd;
        logic        e_rdill;
        logic        e_wrill;
    } vec_t;

    state_t      m = '0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] s_rd;
    logic        s_rdill;
    logic        s_wrill;
    vec_t        tbl [15];

    // {illegal, value} of an address in a given state
    function automatic logic [32:0] mread(input state_t s, input logic [11:0] a);
        case (a)
            12'h340:          return {1'b0, s.ms};
            12'hB00, 12'hC00: return {1'b0, s.cyc[31:0]};
            12'hB80, 12'hC80: return {1'b0, s.cyc[63:32]};
            12'hB02, 12'hC02: return {1'b0, s.ins[31:0]};
            12'hB82, 12'hC82: return {1'b0, s.ins[63:32]};
            default: begin
                if (a >= 12'h7C0 && a <= 12'h7C3) return {1'b0, s.sc[a[1:0]]};
                return {1'b1, 32'h0};
            end
        endcase
    endfunction

    function automatic state_t mwrite(input state_t s, input logic [11:0] a,
                                      input logic [1:0] op, input logic [31:0] d);
        state_t      t;
        logic [32:0] o;
        logic [31:0] nv;
        t = s;
        o = mread(s, a);
        case (op)
            2'b01:   nv = d;
            2'b10:   nv = o[31:0] | d;
            2'b11:   nv = o[31:0] & ~d;
            default: nv = o[31:0];
        endcase
        case (a)
            12'h340: t.ms = nv;
            12'hB00: t.cyc[31:0] = nv;
            12'hB80: t.cyc[63:32] = nv;
            12'hB02: t.ins[31:0] = nv;
            12'hB82: t.ins[63:32] = nv;
            default: if (a >= 12'h7C0 && a <= 12'h7C3) t.sc[a[1:0]] = nv;
        endcase
        return t;
    endfunction

    // Read address names the register being written (directly or via its shadow)
    function automatic bit same_reg(input logic [11:0] ra, input logic [11:0] wa);
        return (ra == wa) || (wa[11:8] == 4'hB && ra == wa + 12'h100);
    endfunction

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model
    task automatic step(input bit chk, input logic r, input logic w, input logic [1:0] op,
                        input logic [11:0] wa, input logic [31:0] wd,
                        input logic ret, input logic [11:0] ra);
        state_t      post;
        logic [32:0] cur;
        logic [32:0] wold;
        bit          ok;
        bit          cw;
        bit          iw;
        @(negedge clk);
        rst = r; we = w; wr_op = op; wr_addr = wa; wr_data = wd; retire = ret; rd_addr = ra;
        #1;
        s_rd = rd_data; s_rdill = rd_illegal; s_wrill = wr_illegal;
        wold = mread(m, wa);
        post = mwrite(m, wa, op, wd);
        ok   = w && (op != 2'b00) && !wold[32] && (wa[11:10] != 2'b11);
        cur  = (ok && same_reg(ra, wa)) ? mread(post, ra) : mread(m, ra);
        if (chk) begin
            chk32($sformatf("model rd_data @%h", ra), s_rd, cur[31:0]);
            chk1($sformatf("model rd_illegal @%h", ra), s_rdill, cur[32]);
            chk1($sformatf("model wr_illegal @%h", wa), s_wrill, w && (op != 2'b00) && !ok);
        end
        @(posedge clk);
        if (r) begin
            m = '0;
        end else begin
            cw = ok && (wa == 12'hB00 || wa == 12'hB80);
            iw = ok && (wa == 12'hB02 || wa == 12'hB82);
            if (ok) m = post;
            if (!cw) m.cyc = m.cyc + 64'd1;
            if (ret && !iw) m.ins = m.ins + 64'd1;
        end
    endtask

    task automatic rd(input logic [11:0] ra, input logic [31:0] exp, input string name);
        step(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, ra);
        chk32(name, s_rd, exp);
    endtask

    logic [11:0] pool [15] = '{12'h340, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'h7C4,
                               12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                               12'hC02, 12'hC82, 12'h123};

    initial begin
        //           we    op     wa       wd            ret   ra       e_rd          rdill wrill
        tbl[0]  = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'hB00, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'hB00, 32'h1,        1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'h340, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'h7C0, 32'h0,        1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'hB02, 32'h0,        1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'h123, 32'h0,        1'b1, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 12'h340, 32'hF0F0F0F0, 1'b0, 12'h340, 32'hF0F0F0F0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 12'h340, 32'h0000000F, 1'b0, 12'h340, 32'hF0F0F0FF, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 12'h340, 32'hF0000000, 1'b0, 12'h340, 32'h00F0F0FF, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'h340, 32'h00F0F0FF, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'b01, 12'hC00, 32'h5,        1'b0, 12'h340, 32'h00F0F0FF, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 2'b01, 12'h7C4, 32'h1,        1'b0, 12'h7C4, 32'h0,        1'b1, 1'b1};
        tbl[12] = '{1'b1, 2'b01, 12'h7C3, 32'hDEADBEEF, 1'b0, 12'h7C3, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 2'b00, 12'h340, 32'hFFFFFFFF, 1'b0, 12'h340, 32'h00F0F0FF, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 12'h7C3, 32'hDEADBEEF, 1'b0, 1'b0};

        step(1'b0, 1'b1, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 12'h000);
        step(1'b0, 1'b1, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 12'h000);

        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, tbl[i].we, tbl[i].op, tbl[i].wa, tbl[i].wd, tbl[i].ret, tbl[i].ra);
            chk32($sformatf("tbl[%0d] rd_data", i), s_rd, tbl[i].e_rd);
            chk1($sformatf("tbl[%0d] rd_illegal", i), s_rdill, tbl[i].e_rdill);
            chk1($sformatf("tbl[%0d] wr_illegal", i), s_wrill, tbl[i].e_wrill);
        end

        // mcycle low-to-high carry
        step(1'b1, 1'b0, 1'b1, 2'b01, 12'hB00, 32'hFFFFFFFE, 1'b0, 12'hB00);
        chk32("mcycle bypass", s_rd, 32'hFFFFFFFE);
        step(1'b1, 1'b0, 1'b1, 2'b01, 12'hB80, 32'h0, 1'b0, 12'hC80);
        chk32("cycleh shadow bypass", s_rd, 32'h0);
        rd(12'hB00, 32'hFFFFFFFE, "mcycle held during high write");
        rd(12'hC00, 32'hFFFFFFFF, "cycle shadow count");
        rd(12'hB00, 32'h0,        "mcycle low wrap");
        rd(12'hB80, 32'h1,        "mcycleh carry");

        // all-ones wrap to zero
        step(1'b1, 1'b0, 1'b1, 2'b01, 12'hB00, 32'hFFFFFFFF, 1'b0, 12'h340);
        step(1'b1, 1'b0, 1'b1, 2'b01, 12'hB80, 32'hFFFFFFFF, 1'b0, 12'hB00);
        chk32("mcycle all-ones low", s_rd, 32'hFFFFFFFF);
        rd(12'hB80, 32'hFFFFFFFF, "mcycleh all-ones");
        rd(12'hB00, 32'h0,        "mcycle full wrap low");
        rd(12'hB80, 32'h0,        "mcycle full wrap high");

        // minstret retire counting
        step(1'b1, 1'b0, 1'b1, 2'b01, 12'hB02, 32'h0, 1'b1, 12'hB02);
        step(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b1, 12'hB02);
        step(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 12'hB02);
        step(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b1, 12'hB02);
        step(1'b1, 1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b1, 12'hB02);
        rd(12'hB02, 32'h3, "minstret after 1,0,1,1");
        step(1'b1, 1'b0, 1'b1, 2'b01, 12'hB02, 32'h10, 1'b1, 12'hC02);
        chk32("instret shadow bypass", s_rd, 32'h10);
        rd(12'hB02, 32'h10, "minstret write beats retire");

        // reset during counting with a pending write
        step(1'b0, 1'b1, 1'b1, 2'b01, 12'h7C0, 32'h0000ABCD, 1'b1, 12'h340);
        rd(12'hB00, 32'h0, "mcycle after reset");
        rd(12'h340, 32'h0, "mscratch after reset");
        rd(12'h7C0, 32'h0, "scratch0 write discarded");
        rd(12'h7C3, 32'h0, "scratch3 after reset");
        rd(12'hB02, 32'h0, "minstret after reset");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic [11:0] wa;
            logic [11:0] ra;
            logic [31:0] wd;
            r  = ($urandom_range(0, 49) == 0);
            wa = ($urandom_range(0, 15) == 15) ? 12'($urandom) : pool[$urandom_range(0, 14)];
            ra = ($urandom_range(0, 3) == 0) ? wa : pool[$urandom_range(0, 14)];
            wd = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                             : 32'($urandom);
            step(!r, r, 1'($urandom), 2'($urandom), wa, wd, 1'($urandom), ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
